// File: rtl/dac_spi_writer.sv
// -----------------------------------------------------------------------------
// dac_spi_writer
//
// Serial back-end for the DAC path. Takes one two's-complement DAC code per
// transaction and builds a 24-bit frame {CMD, channel nibble, left-justified
// code}. It shifts the frame out MSB first to an external multi-channel SPI
// DAC. After the frame it can give an optional active-low LDAC pulse, so that
// several channels can be loaded first and then updated together.
//
// Ports:
//   clk, rst_n    system clock (rising edge), asynchronous active-low reset
//   code_in       DAC code, two's complement, DAC_WIDTH bits
//   ch_in         target DAC channel, CH_WIDTH bits
//   ldac_in       1 = pulse ldac_n after this frame
//   in_valid      transaction request
//   in_ready      block can accept (IDLE, or the DONE cycle)
//   sclk          SPI clock, idle low
//   sdi           SPI data, MSB first
//   cs_n          SPI chip select, active low
//   ldac_n        DAC load strobe, active low
//   busy          high from the cycle after accept until done
//   done          one-cycle pulse at the end of a transaction
//   dbg_state     current FSM state (IDLE=0 SHIFT=1 CS_HOLD=2 LDAC=3 DONE=4)
//
// Handshake: a transaction is accepted on a rising clk edge where
// in_valid && in_ready. code_in, ch_in and ldac_in are captured on that edge.
// Changes to them later are ignored. in_valid while in_ready is low is
// dropped, not queued. in_ready is also high in the DONE cycle, so a new
// request can be accepted back-to-back with no idle cycle.
// -----------------------------------------------------------------------------
module dac_spi_writer #(
    parameter int unsigned DAC_WIDTH     = 14,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CH_WIDTH      = 2,
    parameter logic [3:0]  CMD           = 4'h3,
    parameter bit          OFFSET_BINARY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DAC_WIDTH-1:0] code_in,
    input  logic [CH_WIDTH-1:0]  ch_in,
    input  logic                 ldac_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 sclk,
    output logic                 sdi,
    output logic                 cs_n,
    output logic                 ldac_n,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CS_HOLD = 3'd2,
        LDAC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // The phase counter must hold values up to 2*CLK_DIV-1 (one full bit).
    localparam int unsigned        CNT_W      = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   HIGH_START = CNT_W'(CLK_DIV);

    // XOR with the MSB turns two's complement into offset binary.
    localparam logic [DAC_WIDTH-1:0] MSB_MASK =
        OFFSET_BINARY ? (DAC_WIDTH'(1) << (DAC_WIDTH - 1)) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_q, bit_d;
    logic [23:0]        shift_q, shift_d;
    logic               ldac_q, ldac_d;

    logic [DAC_WIDTH-1:0] code_ob;
    logic [15:0]          data_field;
    logic [23:0]          frame;
    logic                 accept;

    // Frame assembly: the code sits left-justified in the 16-bit data field.
    assign code_ob    = code_in ^ MSB_MASK;
    assign data_field = 16'(code_ob) << (16 - DAC_WIDTH);
    assign frame      = {CMD, 4'(ch_in), data_field};

    assign in_ready = (state_q == IDLE) || (state_q == DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ldac_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ldac_q  <= ldac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ldac_d  = ldac_q;

        case (state_q)
            IDLE, DONE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = SHIFT;
                    bit_d   = 5'd23;
                    shift_d = frame;
                    ldac_d  = ldac_in;
                end else begin
                    state_d = IDLE;
                end
            end

            // One bit is CLK_DIV cycles low, then CLK_DIV cycles high. The
            // shift happens on the edge that ends the high phase, so the next
            // bit appears on sdi together with the falling sclk edge.
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CS_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = ldac_q ? LDAC : DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LDAC: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode from registered state only. Because reset clears the
    // state asynchronously, the SPI pins go to their idle levels at once.
    assign busy      = (state_q == SHIFT) || (state_q == CS_HOLD) || (state_q == LDAC);
    assign done      = (state_q == DONE);
    assign cs_n      = (state_q != SHIFT);
    assign sclk      = (state_q == SHIFT) && (cnt_q >= HIGH_START);
    assign sdi       = (state_q == SHIFT) && shift_q[23];
    assign ldac_n    = (state_q != LDAC);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_writer
//
// Two instances: u_dut0 (CLK_DIV=2, offset binary) and u_dut1 (CLK_DIV=1,
// plain two's complement). Drivers push {ldac, frame} into a per-instance
// expected queue at accept. A negedge monitor rebuilds each frame from the SPI
// pins, measures its timing, and compares when done pulses.
// -----------------------------------------------------------------------------
module tb_dac_spi_writer;

    localparam int DW  = 14;
    localparam int CW  = 2;
    localparam int D0  = 2;
    localparam int D1  = 1;
    localparam bit OB0 = 1'b1;
    localparam bit OB1 = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [DW-1:0] code_in  [2];
    logic [CW-1:0] ch_in    [2];
    logic          ldac_in  [2];
    logic          in_valid [2];
    logic          in_ready [2];
    logic          sclk     [2];
    logic          sdi      [2];
    logic          cs_n     [2];
    logic          ldac_n   [2];
    logic          busy     [2];
    logic          done     [2];
    logic [2:0]    dbg_state[2];

    dac_spi_writer #(
        .DAC_WIDTH(DW), .CLK_DIV(D0), .CH_WIDTH(CW), .CMD(4'h3), .OFFSET_BINARY(OB0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .code_in(code_in[0]), .ch_in(ch_in[0]),
        .ldac_in(ldac_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .sclk(sclk[0]), .sdi(sdi[0]), .cs_n(cs_n[0]), .ldac_n(ldac_n[0]),
        .busy(busy[0]), .done(done[0]), .dbg_state(dbg_state[0])
    );

    dac_spi_writer #(
        .DAC_WIDTH(DW), .CLK_DIV(D1), .CH_WIDTH(CW), .CMD(4'h3), .OFFSET_BINARY(OB1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .code_in(code_in[1]), .ch_in(ch_in[1]),
        .ldac_in(ldac_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .sclk(sclk[1]), .sdi(sdi[1]), .cs_n(cs_n[1]), .ldac_n(ldac_n[1]),
        .busy(busy[1]), .done(done[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [24:0] exp_q0[$];
    logic [24:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = CMD*2^20 + ch*2^16 + code*2^(16-DW). Offset
    // binary is the signed code plus half scale, taken modulo full scale.
    function automatic logic [23:0] model(input int code, input int ch, input bit ob);
        int c;
        int f;
        c = ob ? (code + (1 << (DW - 1))) % (1 << DW) : code;
        f = 3 * (1 << 20) + ch * (1 << 16) + c * (1 << (16 - DW));
        return f[23:0];
    endfunction

    // ---------------- monitor ----------------
    bit          act       [2];
    int          t         [2];
    int          rises     [2];
    int          cs_low    [2];
    int          ldac_low  [2];
    int          first_rise[2];
    int          unstable  [2];
    int          bad_hs    [2];
    int          b2b       [2];
    int          viol = 0;
    logic [23:0] bits      [2];
    logic        rise_sdi  [2];
    logic        sclk_prev [2];

    task automatic finish_tx(input int i, input int d);
        logic [24:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        if (i == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        if (i == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        check("exp_available", 32'(have), 32'd1);
        if (have) begin
            check("frame",        32'(bits[i]),     32'(e[23:0]));
            check("sclk_rises",   32'(rises[i]),    32'd24);
            check("cs_low_len",   32'(cs_low[i]),   32'(48 * d));
            check("ldac_low_len", 32'(ldac_low[i]), e[24] ? 32'(d) : 32'd0);
            check("done_cycle",   32'(t[i]),        e[24] ? 32'(50 * d + 1) : 32'(49 * d + 1));
            check("first_rise",   32'(first_rise[i]), 32'(d + 1));
            check("sdi_stable",   32'(unstable[i]), 32'd0);
            check("busy_ready_during", 32'(bad_hs[i]), 32'd0);
            check("busy_at_done",  32'(busy[i]),     32'd0);
            check("ready_at_done", 32'(in_ready[i]), 32'd1);
        end
    endtask

    task automatic mon_step(input int i, input int d);
        if (!rst_n) begin
            // An abandoned frame never reaches done; drop its expectation.
            if (act[i]) begin
                if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
                if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
            end
            act[i] = 1'b0;
            sclk_prev[i] = 1'b0;
            return;
        end
        if (!cs_n[i] && !ldac_n[i]) viol++;
        if (sclk[i] && cs_n[i]) viol++;
        if (act[i]) begin
            t[i]++;
            if (!cs_n[i]) cs_low[i]++;
            if (!ldac_n[i]) ldac_low[i]++;
            if (sclk[i] && !sclk_prev[i]) begin
                rises[i]++;
                bits[i] = {bits[i][22:0], sdi[i]};
                rise_sdi[i] = sdi[i];
                if (rises[i] == 1) first_rise[i] = t[i];
            end else if (sclk[i] && (sdi[i] !== rise_sdi[i])) begin
                unstable[i]++;
            end
            if (done[i]) begin
                finish_tx(i, d);
                act[i] = 1'b0;
            end else begin
                if (busy[i] !== 1'b1 || in_ready[i] !== 1'b0) bad_hs[i]++;
                if (t[i] > 200) begin
                    check("tx_timeout", 32'(t[i]), 32'd200);
                    act[i] = 1'b0;
                end
            end
        end
        sclk_prev[i] = sclk[i];
        // Accept happens on the next rising edge; that edge is cycle 0.
        if (in_valid[i] && in_ready[i]) begin
            if (done[i]) b2b[i]++;
            act[i] = 1'b1;
            t[i] = 0;
            rises[i] = 0;
            cs_low[i] = 0;
            ldac_low[i] = 0;
            first_rise[i] = 0;
            unstable[i] = 0;
            bad_hs[i] = 0;
            bits[i] = '0;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, D0);
        mon_step(1, D1);
    end

    // ---------------- drivers ----------------
    // All drivers start and end at posedge + #1.
    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!act[i] && in_ready[i]) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_one(input int i, input logic [DW-1:0] c, input logic [CW-1:0] ch,
                             input logic l, input bit noise, input bit keep_valid);
        bit ok;
        logic [24:0] e;
        code_in[i]  = c;
        ch_in[i]    = ch;
        ldac_in[i]  = l;
        in_valid[i] = 1'b1;
        wait_accept(i, ok);
        if (ok) begin
            e = {l, model(int'(c), int'(ch), (i == 0) ? OB0 : OB1)};
            if (i == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        if (!keep_valid) in_valid[i] = 1'b0;
        if (noise) begin
            // Requests and input changes while busy must be ignored. This
            // stops well before the shortest transaction (50 cycles) ends.
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                in_valid[i] = 1'($urandom_range(0, 1));
                code_in[i]  = DW'($urandom);
                ch_in[i]    = CW'($urandom);
                ldac_in[i]  = 1'($urandom_range(0, 1));
            end
            in_valid[i] = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    int b2b_start;

    initial begin
        for (int i = 0; i < 2; i++) begin
            code_in[i] = '0; ch_in[i] = '0; ldac_in[i] = 1'b0; in_valid[i] = 1'b0;
            act[i] = 1'b0; b2b[i] = 0; sclk_prev[i] = 1'b0; bits[i] = '0; rise_sdi[i] = 1'b0;
            t[i] = 0; rises[i] = 0; cs_low[i] = 0; ldac_low[i] = 0;
            first_rise[i] = 0; unstable[i] = 0; bad_hs[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",     32'(cs_n[0]),     32'd1);
        check("rst_sclk",     32'(sclk[0]),     32'd0);
        check("rst_ldac_n",   32'(ldac_n[0]),   32'd1);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_busy",     32'(busy[0]),     32'd0);
        check("rst_cs_n_1",   32'(cs_n[1]),     32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames.
        drive_one(0, 14'h2000, 2'd1, 1'b0, 1'b0, 1'b0); wait_idle(0);
        drive_one(0, 14'h1FFF, 2'd3, 1'b1, 1'b0, 1'b0); wait_idle(0);
        drive_one(0, 14'h0000, 2'd2, 1'b0, 1'b0, 1'b0); wait_idle(0);
        drive_one(1, 14'h0000, 2'd2, 1'b0, 1'b0, 1'b0); wait_idle(1);
        drive_one(1, 14'h2A5C, 2'd1, 1'b1, 1'b0, 1'b0); wait_idle(1);

        // Back-to-back: four writes with in_valid held, LDAC only on the last.
        b2b_start = b2b[0];
        drive_one(0, 14'h0123, 2'd0, 1'b0, 1'b0, 1'b1);
        drive_one(0, 14'h3456, 2'd1, 1'b0, 1'b0, 1'b1);
        drive_one(0, 14'h2789, 2'd2, 1'b0, 1'b0, 1'b1);
        drive_one(0, 14'h1ABC, 2'd3, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        check("b2b_accepts_in_done", 32'(b2b[0] - b2b_start), 32'd3);

        // Reset in the middle of SHIFT. Outputs must idle without a clock edge.
        drive_one(0, 14'h1FFF, 2'd3, 1'b1, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cs_n",     32'(cs_n[0]),     32'd1);
        check("arst_sclk",     32'(sclk[0]),     32'd0);
        check("arst_sdi",      32'(sdi[0]),      32'd0);
        check("arst_ldac_n",   32'(ldac_n[0]),   32'd1);
        check("arst_in_ready", 32'(in_ready[0]), 32'd1);
        check("arst_busy",     32'(busy[0]),     32'd0);
        check("arst_done",     32'(done[0]),     32'd0);
        check("arst_state",    32'(dbg_state[0]), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_one(0, 14'h0F0F, 2'd2, 1'b1, 1'b0, 1'b0); wait_idle(0);

        // Randomized traffic with noise on the inputs while busy.
        for (int n = 0; n < 24; n++) begin
            int i;
            i = n % 2;
            drive_one(i, DW'($urandom), CW'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            wait_idle(i);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("invariant_viol", 32'(viol), 32'd0);
        check("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
